// File: rtl/pe_pkg.sv
// pe_pkg: widths shared across the PE (multiplier and accumulator) and the accumulator FSM states.
package pe_pkg;
    localparam int WIDTH_A   = 16;
    localparam int WIDTH_B   = 16;
    localparam int WIDTH_MUL = 32;
    localparam int WIDTH_ACC = 40;
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
endpackage

// File: rtl/pe_accumulator.sv
// pe_accumulator: sums a group of unsigned products into one result held until the consumer takes it.
module pe_accumulator #(
    parameter int WIDTH_MUL = pe_pkg::WIDTH_MUL,
    parameter int WIDTH_ACC = pe_pkg::WIDTH_ACC,
    parameter int SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH_MUL-1:0] in_prod,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_ACC-1:0] out_acc,
    output logic [15:0]          out_count,
    output logic                 out_ovf
);
    import pe_pkg::*;

    state_t               state_q, state_d;
    logic [WIDTH_ACC-1:0] acc_q, acc_d;
    logic [15:0]          count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 accept;
    logic [WIDTH_ACC:0]   prod_ext;
    logic [WIDTH_ACC:0]   sum;

    assign in_ready = (state_q != HOLD) || out_ready;
    assign accept   = in_valid && in_ready;
    assign prod_ext = {{(WIDTH_ACC + 1 - WIDTH_MUL){1'b0}}, in_prod};
    assign sum      = {1'b0, acc_q} + prod_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A beat accepted in HOLD starts the next group with no bubble.
    always_comb begin
        state_d = state_q;
        if (accept) state_d = in_last ? HOLD : ACCUM;
        else if (state_q == HOLD && out_ready) state_d = IDLE;
    end

    always_comb begin
        out_valid = (state_q == HOLD);
        out_acc   = acc_q;
        out_count = count_q;
        out_ovf   = ovf_q;
    end

    // Once saturated, the sum stays pinned at all-ones for the rest of the group.
    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (accept && state_q != ACCUM) begin
            acc_d   = prod_ext[WIDTH_ACC-1:0];
            count_d = 16'd1;
            ovf_d   = 1'b0;
        end else if (accept) begin
            acc_d   = (SATURATE != 0 && (sum[WIDTH_ACC] || ovf_q)) ? '1 : sum[WIDTH_ACC-1:0];
            count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            ovf_d   = ovf_q | sum[WIDTH_ACC];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_pe_accumulator.sv
// tb_pe_accumulator: directed vectors for the default block plus 33-bit wrap and saturate variants.
module tb_pe_accumulator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_prod;
    logic        in_last;
    logic        out_ready;
    logic        rdy_d, rdy_w, rdy_s;
    logic        vld_d, vld_w, vld_s;
    logic [39:0] acc_d;
    logic [32:0] acc_w, acc_s;
    logic [15:0] cnt_d, cnt_w, cnt_s;
    logic        ovf_d, ovf_w, ovf_s;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pe_accumulator u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_prod(in_prod), .in_last(in_last),
        .in_ready(rdy_d), .out_valid(vld_d), .out_ready(out_ready), .out_acc(acc_d),
        .out_count(cnt_d), .out_ovf(ovf_d)
    );

    pe_accumulator #(.WIDTH_MUL(32), .WIDTH_ACC(33), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_prod(in_prod), .in_last(in_last),
        .in_ready(rdy_w), .out_valid(vld_w), .out_ready(out_ready), .out_acc(acc_w),
        .out_count(cnt_w), .out_ovf(ovf_w)
    );

    pe_accumulator #(.WIDTH_MUL(32), .WIDTH_ACC(33), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_prod(in_prod), .in_last(in_last),
        .in_ready(rdy_s), .out_valid(vld_s), .out_ready(out_ready), .out_acc(acc_s),
        .out_count(cnt_s), .out_ovf(ovf_s)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] p, input logic last);
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", vld_d, 0);
        check("rst_acc", acc_d, 0);
        check("rst_count", cnt_d, 0);
        check("rst_ovf", ovf_d, 0);
        check("rst_ready", rdy_d, 1);
        rst_n = 1'b1;

        beat(32'd3, 0);
        beat(32'd5, 0);
        beat(32'd7, 0);
        check("sum_mid_valid", vld_d, 0);
        check("sum_mid_acc", acc_d, 15);
        beat(32'd9, 1);
        check("sum_valid", vld_d, 1);
        check("sum_acc", acc_d, 24);
        check("sum_count", cnt_d, 4);
        check("sum_ovf", ovf_d, 0);
        tick();
        check("sum_drop", vld_d, 0);

        beat(32'hFFFE0001, 1);
        check("one_valid", vld_d, 1);
        check("one_acc", acc_d, 64'h00FFFE0001);
        check("one_count", cnt_d, 1);
        tick();
        check("one_drop", vld_d, 0);

        out_ready = 1'b0;
        beat(32'd1, 0);
        beat(32'd2, 1);
        in_valid = 1'b1;
        in_prod  = 32'd99;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", rdy_d, 0);
            tick();
            check("bp_valid", vld_d, 1);
            check("bp_acc", acc_d, 3);
            check("bp_count", cnt_d, 2);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release", vld_d, 0);
        check("bp_release_acc", acc_d, 3);

        beat(32'd5, 1);
        check("b2b_first", acc_d, 5);
        check("b2b_first_valid", vld_d, 1);
        check("b2b_ready", rdy_d, 1);
        beat(32'd10, 0);
        check("b2b_mid_valid", vld_d, 0);
        check("b2b_mid_acc", acc_d, 10);
        beat(32'd20, 1);
        check("b2b_valid", vld_d, 1);
        check("b2b_acc", acc_d, 30);
        check("b2b_count", cnt_d, 2);
        tick();

        beat(32'hFFFFFFFF, 0);
        beat(32'hFFFFFFFF, 0);
        check("ovf2_wrap_ovf", ovf_w, 0);
        check("ovf2_wrap_acc", acc_w, 64'h1FFFFFFFE);
        beat(32'hFFFFFFFF, 1);
        check("ovf_wrap_valid", vld_w, 1);
        check("ovf_wrap_acc", acc_w, 64'h0FFFFFFFD);
        check("ovf_wrap_ovf", ovf_w, 1);
        check("ovf_sat_acc", acc_s, 64'h1FFFFFFFF);
        check("ovf_sat_ovf", ovf_s, 1);
        check("ovf_wide_acc", acc_d, 64'h2FFFFFFFD);
        check("ovf_wide_ovf", ovf_d, 0);
        tick();

        beat(32'hFFFFFFFF, 0);
        beat(32'hFFFFFFFF, 0);
        beat(32'hFFFFFFFF, 0);
        beat(32'd5, 1);
        check("stick_wrap_acc", acc_w, 64'h100000002);
        check("stick_wrap_ovf", ovf_w, 1);
        check("stick_sat_acc", acc_s, 64'h1FFFFFFFF);
        check("stick_sat_ovf", ovf_s, 1);
        check("stick_count", cnt_s, 4);
        tick();

        beat(32'd4, 0);
        beat(32'd6, 0);
        rst_n = 1'b0;
        tick();
        check("mrst_valid", vld_d, 0);
        check("mrst_acc", acc_d, 0);
        check("mrst_count", cnt_d, 0);
        check("mrst_ready", rdy_d, 1);
        rst_n = 1'b1;
        tick();
        check("mrst_idle", vld_d, 0);
        beat(32'd1, 0);
        check("mrst_g1_valid", vld_d, 0);
        beat(32'd2, 1);
        check("mrst_valid2", vld_d, 1);
        check("mrst_acc2", acc_d, 3);
        check("mrst_count2", cnt_d, 2);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
